// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (port A, priority) and the debug/loader port (port B).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_gnt)
//   a_gnt                       port A granted this cycle (combinational)
//   a_rvalid/a_rdata            port A read return, one cycle after grant
//   b_*                         same as port A, for port B
//   mem_read/mem_write          strobes to data memory (combinational)
//   mem_addr/mem_wdata          address / write data to data memory
//   mem_rdata                   read data from data memory
//
// Build option: define DMEM_ARB_STARVE_EN to add the starvation guard that
// forces a B grant after STARVE_MAX consecutive contested A grants. Without
// it, A has strict priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    // Reject limits the 4-bit counter cannot represent.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dmem_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   force_b;

`ifdef DMEM_ARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    assign force_b = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts contested A grants; any B grant or idle B clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (b_gnt || !b_req) begin
            starve_cnt <= '0;
        end else if (a_gnt && !force_b) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_b = 1'b0;
`endif

    // Fixed priority to A, overridden when B has waited too long.
    assign a_gnt = a_req & ~(b_req & force_b);
    assign b_gnt = b_req & (~a_req | force_b);

    // Mux the winner onto the memory port; idle bus is all zeros.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_write = a_we;
            mem_read  = ~a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_write = b_we;
            mem_read  = ~b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Read-owner register: remembers who gets next cycle's return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (a_gnt && !a_we) begin
            state_nxt = RD_A;
        end else if (b_gnt && !b_we) begin
            state_nxt = RD_B;
        end
    end

    assign a_rvalid = (state == RD_A);
    assign b_rvalid = (state == RD_B);

    // Read data is captured at the end of the grant cycle and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_gnt && !a_we) begin
                a_rdata <= mem_rdata;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: asynchronous read, write on the rising edge.
    logic [DATA_W-1:0] mem_arr [8192];
    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, pending read returns, wait count.
    logic [DATA_W-1:0] shadow [8192];
    int                m_cnt = 0;
    logic              m_arv = 1'b0, m_brv = 1'b0;
    logic [DATA_W-1:0] m_ard = '0, m_brd = '0;
    int                win;
    logic              m_force;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem_arr[i] = '0;
            shadow[i]  = '0;
        end
        mem_arr[5] = 32'hDEAD_BEEF;
        shadow[5]  = 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_arv = 1'b0;
            m_brv = 1'b0;
            m_ard = '0;
            m_brd = '0;
        end
        m_force = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
        m_force = (m_cnt == int'(STARVE_MAX));
`endif
        // win: 0 none, 1 port A, 2 port B
        if (a_req && b_req)  win = m_force ? 2 : 1;
        else if (a_req)      win = 1;
        else if (b_req)      win = 2;
        else                 win = 0;

        e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (win == 1) begin e_we = a_we; e_addr = a_addr; e_wdata = a_wdata; end
        if (win == 2) begin e_we = b_we; e_addr = b_addr; e_wdata = b_wdata; end

        check("a_gnt",     32'(a_gnt),     32'(win == 1));
        check("b_gnt",     32'(b_gnt),     32'(win == 2));
        check("mem_read",  32'(mem_read),  32'(win != 0 && !e_we));
        check("mem_write", 32'(mem_write), 32'(win != 0 && e_we));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_wdata", mem_wdata,      e_wdata);
        check("a_rvalid",  32'(a_rvalid),  32'(m_arv));
        check("a_rdata",   a_rdata,        m_ard);
        check("b_rvalid",  32'(b_rvalid),  32'(m_brv));
        check("b_rdata",   b_rdata,        m_brd);

        // Advance the model to what the next cycle must show.
        if (rst_n) begin
            m_arv = (win == 1) && !e_we;
            m_brv = (win == 2) && !e_we;
            if (m_arv) m_ard = shadow[e_addr];
            if (m_brv) m_brd = shadow[e_addr];
            if (win != 0 && e_we) shadow[e_addr] = e_wdata;
            if (win == 2 || !b_req) m_cnt = 0;
            else if (win == 1 && m_cnt < int'(STARVE_MAX)) m_cnt = m_cnt + 1;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    logic [9:0] seq;
    logic [9:0] seq_exp;

    initial begin
        rst_n = 1'b0;
        idle();
        next_cyc();
        mid();
        check("rst a_gnt",     32'(a_gnt),     32'd0);
        check("rst b_gnt",     32'(b_gnt),     32'd0);
        check("rst a_rvalid",  32'(a_rvalid),  32'd0);
        check("rst b_rvalid",  32'(b_rvalid),  32'd0);
        check("rst a_rdata",   a_rdata,        32'd0);
        check("rst b_rdata",   b_rdata,        32'd0);
        check("rst mem_read",  32'(mem_read),  32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // A write then immediate read-back of the same word.
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd0; a_wdata = 32'h1234_5678;
        next_cyc();
        a_we = 1'b0; a_wdata = '0;
        mid();
        check("wr_rd a_gnt", 32'(a_gnt), 32'd1);
        next_cyc();
        idle();
        mid();
        check("wr_rd a_rvalid", 32'(a_rvalid), 32'd1);
        check("wr_rd a_rdata",  a_rdata,       32'h1234_5678);
        next_cyc();

        // B read of preloaded word with A idle.
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd5;
        mid();
        check("brd b_gnt", 32'(b_gnt), 32'd1);
        next_cyc();
        idle();
        mid();
        check("brd b_rvalid", 32'(b_rvalid), 32'd1);
        check("brd b_rdata",  b_rdata,       32'hDEAD_BEEF);
        check("brd a_rvalid", 32'(a_rvalid), 32'd0);
        next_cyc();

        // Alternating A / B reads, one port per cycle.
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i % 2 == 0) begin a_req = 1'b1; a_addr = 13'd5; end
            else            begin b_req = 1'b1; b_addr = 13'd0; end
            next_cyc();
        end
        idle();
        mid();
        check("alt b_rvalid", 32'(b_rvalid), 32'd1);
        check("alt b_rdata",  b_rdata,       32'h1234_5678);
        check("alt a_rvalid", 32'(a_rvalid), 32'd0);
        check("alt a_rdata",  a_rdata,       32'hDEAD_BEEF);
        next_cyc();

        // Contested A read granted, then reset in the following cycle.
        a_req = 1'b1; a_addr = 13'd5;
        b_req = 1'b1; b_addr = 13'd0;
        next_cyc();
        idle();
        #1;
        check("pre-rst a_rvalid", 32'(a_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async a_rvalid", 32'(a_rvalid), 32'd0);
        check("async a_rdata",  a_rdata,       32'd0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Both ports request continuously: guard pattern or strict priority.
        a_req = 1'b1; a_addr = 13'd5;
        b_req = 1'b1; b_addr = 13'd0;
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            mid();
            seq[i] = b_gnt;
            next_cyc();
        end
        idle();
`ifdef DMEM_ARB_STARVE_EN
        seq_exp = 10'b10_0001_0000;
`else
        seq_exp = 10'b00_0000_0000;
`endif
        check("starve seq", 32'(seq), 32'(seq_exp));

        repeat (3) next_cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
